// File: rtl/e203_ifu_bjp_sched_pkg.sv
// Shared IFU definitions: core widths, scheduler state encoding, mini-decoder
// result record and the JALR base-register dependency check.
package e203_ifu_bjp_sched_pkg;

   localparam int E203_XLEN        = 32;
   localparam int E203_PC_SIZE     = 32;
   localparam int E203_INSTR_SIZE  = 32;
   localparam int E203_RFIDX_WIDTH = 5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DEP_WAIT = 3'd1,
      ST_RF_REQ   = 3'd2,
      ST_RF_RD    = 3'd3,
      ST_ISSUE    = 3'd4
   } sched_state_e;

   typedef struct packed {
      logic                        bjp;
      logic                        jal;
      logic                        jalr;
      logic                        bxx;
      logic                        rv32;
      logic [E203_XLEN-1:0]        imm;
      logic [E203_RFIDX_WIDTH-1:0] jalr_rs1idx;
   } minidec_t;

   // Base register is unsafe to read while any long-latency write is in flight
   // or while the instruction sitting in the EXU IR is about to write it.
   function automatic logic jalr_dep(
      input logic                        oitf_empty,
      input logic                        exu_ir_valid,
      input logic                        exu_ir_rdwen,
      input logic [E203_RFIDX_WIDTH-1:0] exu_ir_rdidx,
      input logic [E203_RFIDX_WIDTH-1:0] rs1idx
   );
      return !oitf_empty || (exu_ir_valid && exu_ir_rdwen && (exu_ir_rdidx == rs1idx));
   endfunction

endpackage

// File: rtl/e203_ifu_bjp_sched_if.sv
// Signal bundle between the branch/jump scheduler and its IR, EXU, PC-gen and
// register-file neighbours. master = scheduler, slave = surrounding pipeline.
interface e203_ifu_bjp_sched_if;
   import e203_ifu_bjp_sched_pkg::*;

   logic                        ir_valid;
   logic                        ir_ready;
   logic [E203_INSTR_SIZE-1:0]  ir_instr;
   logic [E203_PC_SIZE-1:0]     ir_pc;
   logic                        o_valid;
   logic                        o_ready;
   logic [E203_INSTR_SIZE-1:0]  o_instr;
   logic [E203_PC_SIZE-1:0]     o_pc;
   logic                        o_prdt_taken;
   logic                        redir_valid;
   logic [E203_PC_SIZE-1:0]     redir_pc;
   logic                        oitf_empty;
   logic                        exu_ir_valid;
   logic                        exu_ir_rdwen;
   logic [E203_RFIDX_WIDTH-1:0] exu_ir_rdidx;
   logic [E203_XLEN-1:0]        rf2ifu_x1;
   logic                        rf_req;
   logic                        rf_gnt;
   logic [E203_RFIDX_WIDTH-1:0] rf_idx;
   logic [E203_XLEN-1:0]        rf_rdata;
   logic                        flush_req;

   modport master (
      input  ir_valid, ir_instr, ir_pc, o_ready, oitf_empty, exu_ir_valid,
             exu_ir_rdwen, exu_ir_rdidx, rf2ifu_x1, rf_gnt, rf_rdata, flush_req,
      output ir_ready, o_valid, o_instr, o_pc, o_prdt_taken, redir_valid,
             redir_pc, rf_req, rf_idx
   );

   modport slave (
      output ir_valid, ir_instr, ir_pc, o_ready, oitf_empty, exu_ir_valid,
             exu_ir_rdwen, exu_ir_rdidx, rf2ifu_x1, rf_gnt, rf_rdata, flush_req,
      input  ir_ready, o_valid, o_instr, o_pc, o_prdt_taken, redir_valid,
             redir_pc, rf_req, rf_idx
   );

endinterface

// File: rtl/e203_ifu_minidec.sv
// Combinational mini-decoder: classifies RV32/RVC branch and jump instructions
// and extracts the sign-extended offset and JALR base register.
module e203_ifu_minidec
   import e203_ifu_bjp_sched_pkg::*;
(
   input  logic [E203_INSTR_SIZE-1:0] instr,
   output minidec_t                   dec
);

   logic       rv32;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [2:0] c_funct3;
   logic       c_q1;
   logic       c_q2;
   logic       i_jal, i_jalr, i_bxx;
   logic       c_j, c_jr, c_bxx;

   assign rv32     = (instr[1:0] == 2'b11);
   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign c_funct3 = instr[15:13];
   assign c_q1     = (instr[1:0] == 2'b01);
   assign c_q2     = (instr[1:0] == 2'b10);

   assign i_jal  = rv32 && (opcode == 7'b1101111);
   assign i_jalr = rv32 && (opcode == 7'b1100111) && (funct3 == 3'b000);
   assign i_bxx  = rv32 && (opcode == 7'b1100011);
   // C.J / C.JAL share the CJ offset format; C.JR / C.JALR need rs2=0 and rs1!=0
   assign c_j    = c_q1 && ((c_funct3 == 3'b101) || (c_funct3 == 3'b001));
   assign c_jr   = c_q2 && (instr[15:13] == 3'b100) && (instr[6:2] == 5'd0)
                   && (instr[11:7] != 5'd0);
   assign c_bxx  = c_q1 && (c_funct3[2:1] == 2'b11);

   always_comb begin
      dec             = '0;
      dec.rv32        = rv32;
      dec.jal         = i_jal | c_j;
      dec.jalr        = i_jalr | c_jr;
      dec.bxx         = i_bxx | c_bxx;
      dec.bjp         = dec.jal | dec.jalr | dec.bxx;
      dec.jalr_rs1idx = rv32 ? instr[19:15] : instr[11:7];
      if (i_jal)
         dec.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      else if (i_jalr)
         dec.imm = {{21{instr[31]}}, instr[30:20]};
      else if (i_bxx)
         dec.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      else if (c_j)
         dec.imm = {{21{instr[12]}}, instr[8], instr[10:9], instr[6], instr[7],
                    instr[2], instr[11], instr[5:3], 1'b0};
      else if (c_bxx)
         dec.imm = {{24{instr[12]}}, instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};
   end

endmodule

// File: rtl/e203_ifu_bjp_sched.sv
// Branch/jump scheduler: holds one IR instruction, resolves JALR base hazards
// via the shared rs1 read port, and issues to the EXU with a next-PC redirect.
module e203_ifu_bjp_sched
   import e203_ifu_bjp_sched_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   e203_ifu_bjp_sched_if.master bus
);

   sched_state_e            state_reg, state_next, accept_state;
   minidec_t                dec, dec_reg;
   logic [E203_INSTR_SIZE-1:0] instr_reg;
   logic [E203_PC_SIZE-1:0] pc_reg;
   logic [E203_XLEN-1:0]    base_reg;
   logic [E203_XLEN-1:0]    jalr_base;
   logic [E203_PC_SIZE-1:0] target;
   logic                    flush, accept, handshake, prdt_taken;
   logic                    dep_new, dep_held;

   e203_ifu_minidec u_minidec (
      .instr (bus.ir_instr),
      .dec   (dec)
   );

   assign flush    = bus.flush_req;
   assign dep_new  = jalr_dep(bus.oitf_empty, bus.exu_ir_valid, bus.exu_ir_rdwen,
                              bus.exu_ir_rdidx, dec.jalr_rs1idx);
   assign dep_held = jalr_dep(bus.oitf_empty, bus.exu_ir_valid, bus.exu_ir_rdwen,
                              bus.exu_ir_rdidx, dec_reg.jalr_rs1idx);

   assign bus.ir_ready = !flush && ((state_reg == ST_IDLE)
                                    || ((state_reg == ST_ISSUE) && bus.o_ready));
   assign bus.o_valid  = !flush && (state_reg == ST_ISSUE);
   assign accept       = bus.ir_valid && bus.ir_ready;
   assign handshake    = bus.o_valid && bus.o_ready;

   assign bus.o_instr      = instr_reg;
   assign bus.o_pc         = pc_reg;
   assign bus.o_prdt_taken = prdt_taken;
   assign bus.redir_valid  = handshake;
   assign bus.redir_pc     = handshake ? target : '0;
   assign bus.rf_req       = (state_reg == ST_RF_REQ);
   assign bus.rf_idx       = bus.rf_req ? dec_reg.jalr_rs1idx : '0;

   // Only backward conditional branches are predicted taken
   assign prdt_taken = dec_reg.jal | dec_reg.jalr | (dec_reg.bxx & dec_reg.imm[E203_XLEN-1]);

   always_comb begin
      jalr_base = base_reg;
      if (dec_reg.jalr_rs1idx == '0)
         jalr_base = '0;
      else if (dec_reg.jalr_rs1idx == E203_RFIDX_WIDTH'(1))
         jalr_base = bus.rf2ifu_x1;
   end

   always_comb begin
      if (prdt_taken)
         target = (dec_reg.jalr ? jalr_base : pc_reg) + dec_reg.imm;
      else
         target = pc_reg + (dec_reg.rv32 ? E203_PC_SIZE'(4) : E203_PC_SIZE'(2));
   end

   // Destination for a freshly accepted instruction, shared by IDLE and ISSUE
   always_comb begin
      accept_state = ST_ISSUE;
      if (dec.jalr && (dec.jalr_rs1idx != '0)) begin
         if (dep_new)
            accept_state = ST_DEP_WAIT;
         else if (dec.jalr_rs1idx != E203_RFIDX_WIDTH'(1))
            accept_state = ST_RF_REQ;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:     if (accept) state_next = accept_state;
         ST_DEP_WAIT: if (!dep_held)
                         state_next = (dec_reg.jalr_rs1idx == E203_RFIDX_WIDTH'(1))
                                      ? ST_ISSUE : ST_RF_REQ;
         ST_RF_REQ:   if (bus.rf_gnt) state_next = ST_RF_RD;
         ST_RF_RD:    state_next = ST_ISSUE;
         ST_ISSUE:    if (handshake) state_next = accept ? accept_state : ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
      if (flush)
         state_next = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         dec_reg   <= '0;
         instr_reg <= '0;
         pc_reg    <= '0;
         base_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            dec_reg   <= dec;
            instr_reg <= bus.ir_instr;
            pc_reg    <= bus.ir_pc;
         end
         if ((state_reg == ST_RF_RD) && !flush)
            base_reg <= bus.rf_rdata;
      end
   end

endmodule

// File: tb/tb_e203_ifu_bjp_sched.sv
// Directed bench for the branch/jump scheduler with hand-computed targets.
module tb_e203_ifu_bjp_sched;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   e203_ifu_bjp_sched_if bus ();

   e203_ifu_bjp_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".o_valid"},      32'(bus.o_valid), 32'd0);
      check({tag, ".redir_valid"},  32'(bus.redir_valid), 32'd0);
      check({tag, ".rf_req"},       32'(bus.rf_req), 32'd0);
      check({tag, ".o_prdt_taken"}, 32'(bus.o_prdt_taken), 32'd0);
      check({tag, ".o_instr"},      bus.o_instr, 32'd0);
      check({tag, ".o_pc"},         bus.o_pc, 32'd0);
      check({tag, ".redir_pc"},     bus.redir_pc, 32'd0);
      check({tag, ".rf_idx"},       32'(bus.rf_idx), 32'd0);
   endtask

   // Single-cycle issue path: accept, then o_valid/redirect on the next cycle.
   task automatic issue_simple(input string tag, input logic [31:0] instr,
                               input logic [31:0] pc, input logic taken,
                               input logic [31:0] rpc);
      bus.ir_valid = 1'b1;
      bus.ir_instr = instr;
      bus.ir_pc    = pc;
      settle();
      check({tag, ".ir_ready"}, 32'(bus.ir_ready), 32'd1);
      tick();
      bus.ir_valid = 1'b0;
      settle();
      check({tag, ".o_valid"},      32'(bus.o_valid), 32'd1);
      check({tag, ".o_instr"},      bus.o_instr, instr);
      check({tag, ".o_pc"},         bus.o_pc, pc);
      check({tag, ".o_prdt_taken"}, 32'(bus.o_prdt_taken), 32'(taken));
      check({tag, ".redir_valid"},  32'(bus.redir_valid), 32'd1);
      check({tag, ".redir_pc"},     bus.redir_pc, rpc);
      tick();
      settle();
      check({tag, ".idle"}, 32'(bus.o_valid), 32'd0);
      $display("txn %s pc=0x%08h taken=%0d redir=0x%08h", tag, pc, taken, bus.redir_pc);
   endtask

   // JALR x5, imm=-4: optional EXU-IR hazard, then a grant delayed by `delay` cycles.
   task automatic jalr_x5(input string tag, input logic dep, input int delay);
      bus.exu_ir_valid = dep;
      bus.exu_ir_rdwen = 1'b1;
      bus.exu_ir_rdidx = 5'd5;
      bus.ir_valid = 1'b1;
      bus.ir_instr = 32'hFFC28067;
      bus.ir_pc    = 32'h0000_0500;
      settle();
      tick();
      bus.ir_valid = 1'b0;
      if (dep) begin
         settle();
         check({tag, ".dep.rf_req"},  32'(bus.rf_req), 32'd0);
         check({tag, ".dep.o_valid"}, 32'(bus.o_valid), 32'd0);
         bus.exu_ir_valid = 1'b0;
         tick();
      end
      for (int i = 0; i < delay; i++) begin
         settle();
         check({tag, ".wait.rf_req"}, 32'(bus.rf_req), 32'd1);
         check({tag, ".wait.rf_idx"}, 32'(bus.rf_idx), 32'd5);
         tick();
      end
      bus.rf_gnt = 1'b1;
      settle();
      check({tag, ".gnt.rf_req"}, 32'(bus.rf_req), 32'd1);
      check({tag, ".gnt.rf_idx"}, 32'(bus.rf_idx), 32'd5);
      tick();
      bus.rf_gnt   = 1'b0;
      bus.rf_rdata = 32'h0000_4000;
      settle();
      check({tag, ".rd.rf_req"},  32'(bus.rf_req), 32'd0);
      check({tag, ".rd.o_valid"}, 32'(bus.o_valid), 32'd0);
      tick();
      bus.rf_rdata = 32'hDEAD_BEEF;
      settle();
      check({tag, ".o_valid"},      32'(bus.o_valid), 32'd1);
      check({tag, ".o_prdt_taken"}, 32'(bus.o_prdt_taken), 32'd1);
      check({tag, ".redir_pc"},     bus.redir_pc, 32'h0000_3FFC);
      $display("txn %s jalr x5 redir=0x%08h", tag, bus.redir_pc);
      tick();
   endtask

   logic [31:0] s_instr [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
   logic [4:0]  rdy_pat = 5'b11101;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_in, n_out, k;

      bus.ir_valid     = 1'b0;
      bus.ir_instr     = '0;
      bus.ir_pc        = '0;
      bus.o_ready      = 1'b1;
      bus.oitf_empty   = 1'b1;
      bus.exu_ir_valid = 1'b0;
      bus.exu_ir_rdwen = 1'b0;
      bus.exu_ir_rdidx = '0;
      bus.rf2ifu_x1    = '0;
      bus.rf_gnt       = 1'b0;
      bus.rf_rdata     = '0;
      bus.flush_req    = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      settle();
      check_outputs_zero("reset");
      rst = 1'b0;
      tick();

      issue_simple("jal",   32'h020000EF, 32'h0000_0100, 1'b1, 32'h0000_0120);
      issue_simple("beq_bk", 32'hFE000CE3, 32'h0000_0200, 1'b1, 32'h0000_01F8);
      issue_simple("bne_fw", 32'h00001463, 32'h0000_0200, 1'b0, 32'h0000_0204);
      issue_simple("c_add", 32'h00009086, 32'h0000_0300, 1'b0, 32'h0000_0302);

      // JALR x1 behind an outstanding long-latency write
      bus.oitf_empty = 1'b0;
      bus.ir_valid   = 1'b1;
      bus.ir_instr   = 32'h00408067;
      bus.ir_pc      = 32'h0000_0400;
      settle();
      tick();
      bus.ir_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         check("jalr_x1.dep_wait", 32'(bus.o_valid), 32'd0);
         tick();
      end
      bus.oitf_empty = 1'b1;
      bus.rf2ifu_x1  = 32'h0000_8000;
      tick();
      settle();
      check("jalr_x1.o_valid",  32'(bus.o_valid), 32'd1);
      check("jalr_x1.taken",    32'(bus.o_prdt_taken), 32'd1);
      check("jalr_x1.redir_pc", bus.redir_pc, 32'h0000_8004);
      $display("txn jalr_x1 redir=0x%08h", bus.redir_pc);
      tick();

      jalr_x5("jalr_x5", 1'b0, 3);
      jalr_x5("jalr_x5_dep", 1'b1, 0);

      // Flush while requesting the read port, grant in the same cycle
      bus.ir_valid = 1'b1;
      bus.ir_instr = 32'hFFC28067;
      bus.ir_pc    = 32'h0000_0540;
      settle();
      tick();
      bus.ir_valid  = 1'b0;
      bus.flush_req = 1'b1;
      bus.rf_gnt    = 1'b1;
      settle();
      check("flush_rf.redir_valid", 32'(bus.redir_valid), 32'd0);
      check("flush_rf.ir_ready",    32'(bus.ir_ready), 32'd0);
      tick();
      bus.flush_req = 1'b0;
      bus.rf_gnt    = 1'b0;
      bus.rf_rdata  = 32'h0000_1234;
      settle();
      check("flush_rf.rf_req", 32'(bus.rf_req), 32'd0);
      check("flush_rf.idle",   32'(bus.ir_ready), 32'd1);
      tick();
      settle();
      check("flush_rf.o_valid", 32'(bus.o_valid), 32'd0);
      $display("txn flush_in_rf_req");

      // Flush coincident with an issue handshake and a new offer
      bus.ir_valid = 1'b1;
      bus.ir_instr = 32'h020000EF;
      bus.ir_pc    = 32'h0000_0600;
      settle();
      tick();
      bus.ir_instr  = 32'h00100093;
      bus.ir_pc     = 32'h0000_0604;
      bus.flush_req = 1'b1;
      settle();
      check("flush_iss.o_valid",     32'(bus.o_valid), 32'd0);
      check("flush_iss.redir_valid", 32'(bus.redir_valid), 32'd0);
      check("flush_iss.ir_ready",    32'(bus.ir_ready), 32'd0);
      tick();
      bus.flush_req = 1'b0;
      bus.ir_valid  = 1'b0;
      settle();
      check("flush_iss.after", 32'(bus.o_valid), 32'd0);
      check("flush_iss.idle",  32'(bus.ir_ready), 32'd1);
      $display("txn flush_in_issue");

      // Reset while parked in DEP_WAIT
      bus.oitf_empty = 1'b0;
      bus.ir_valid   = 1'b1;
      bus.ir_instr   = 32'h00408067;
      bus.ir_pc      = 32'h0000_0700;
      settle();
      tick();
      bus.ir_valid = 1'b0;
      rst = 1'b1;
      tick();
      settle();
      check_outputs_zero("rst_dep");
      rst = 1'b0;
      bus.oitf_empty = 1'b1;
      tick();
      $display("txn reset_in_dep_wait");

      // Four ALU instructions, EXU ready pattern 1,0,1,1 on valid cycles
      n_in = 0;
      n_out = 0;
      k = 0;
      for (int cyc = 0; cyc < 20 && n_out < 4; cyc++) begin
         bus.ir_valid = (n_in < 4);
         bus.ir_instr = (n_in < 4) ? s_instr[n_in] : 32'd0;
         bus.ir_pc    = 32'h0000_0800 + 32'(4 * n_in);
         bus.o_ready  = 1'b1;
         settle();
         if (bus.o_valid) begin
            bus.o_ready = (k < 5) ? rdy_pat[k] : 1'b1;
            k++;
            settle();
            check("stream.o_instr", bus.o_instr, s_instr[n_out]);
            check("stream.o_pc", bus.o_pc, 32'h0000_0800 + 32'(4 * n_out));
            check("stream.redir_valid", 32'(bus.redir_valid), 32'(bus.o_ready));
            if (bus.o_ready) begin
               check("stream.redir_pc", bus.redir_pc, 32'h0000_0804 + 32'(4 * n_out));
               $display("txn stream[%0d] pc=0x%08h", n_out, bus.o_pc);
               n_out++;
            end
         end
         if (bus.ir_valid && bus.ir_ready)
            n_in++;
         tick();
      end
      bus.ir_valid = 1'b0;
      bus.o_ready  = 1'b1;
      check("stream.issued", 32'(n_out), 32'd4);
      check("stream.accepted", 32'(n_in), 32'd4);
      settle();
      check("stream.drained", 32'(bus.o_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
